// File: rtl/mag_req_scheduler_pkg.sv
// Shared configuration and types for the magnitude request scheduler slice.
// NREQ requesters (2..8) share one engine; W is the operand width.
package mag_sched_pkg;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int RAD_W = 2 * W + 1;
  localparam int MAG_W = W + 1;
  localparam int ID_W  = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/mag_req_scheduler_if.sv
// Request/response bundle between the requesters and the magnitude scheduler.
interface mag_req_scheduler_if;
  import mag_sched_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [MAG_W-1:0]  rsp_mag;
  logic              busy;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_mag, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_mag, busy
  );

endinterface

// File: rtl/mag_req_scheduler_isqrt_seq.sv
// Restoring digit-by-digit integer square root, one root bit per cycle, MSB first.
// The start cycle already resolves the top bit, so done follows MAG_W steps.
module isqrt_seq
  import mag_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [RAD_W-1:0] radicand,
  output logic             done,
  output logic [MAG_W-1:0] root
);

  localparam int PAD_W = 2 * MAG_W;
  localparam int REM_W = MAG_W + 3;
  localparam int CNT_W = $clog2(MAG_W + 1);

  logic [PAD_W-1:0] rad_q;
  logic [REM_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             running;

  logic [PAD_W-1:0] src;
  logic [REM_W-1:0] rem_in;
  logic [REM_W-1:0] rem_shift;
  logic [REM_W-1:0] trial;
  logic [REM_W-1:0] rem_next;
  logic [MAG_W-1:0] root_in;
  logic [MAG_W-1:0] root_next;

  // One restoring step: bring down the next radicand pair and try root*4+1.
  always_comb begin
    src       = start ? PAD_W'(radicand) : rad_q;
    rem_in    = start ? '0 : rem_q;
    root_in   = start ? '0 : root;
    rem_shift = {rem_in[REM_W-3:0], src[PAD_W-1 -: 2]};
    trial     = REM_W'({root_in, 2'b01});
    rem_next  = rem_shift;
    root_next = {root_in[MAG_W-2:0], 1'b0};
    if (rem_shift >= trial) begin
      rem_next  = rem_shift - trial;
      root_next = {root_in[MAG_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q   <= '0;
      rem_q   <= '0;
      root    <= '0;
      cnt_q   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      rad_q   <= src << 2;
      rem_q   <= rem_next;
      root    <= root_next;
      cnt_q   <= CNT_W'(1);
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      rad_q <= src << 2;
      rem_q <= rem_next;
      root  <= root_next;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(MAG_W - 1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/mag_req_scheduler.sv
// Round-robin scheduler sharing one sequential floor(sqrt(x^2+y^2)) engine
// between NREQ requesters, returning tagged results on one response channel.
module mag_req_scheduler
  import mag_sched_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  mag_req_scheduler_if.slave bus
);

  state_t           state;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic [W-1:0]     x_q;
  logic [W-1:0]     y_q;
  logic [RAD_W-1:0] sum_sq;
  logic             eng_start;
  logic             eng_done;
  logic [MAG_W-1:0] eng_root;

  // First valid requester after the last one served, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = last;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && bus.req_valid[(int'(last) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'((int'(last) + k) % NREQ);
      end
    end
  end

  assign bus.req_ready = (rst_n && state == IDLE && grant_any) ?
                         (NREQ'(1) << grant_id) : '0;

  // The engine's radicand register captures this sum on the LOAD edge.
  assign sum_sq    = RAD_W'(x_q) * RAD_W'(x_q) + RAD_W'(y_q) * RAD_W'(y_q);
  assign eng_start = (state == LOAD);

  isqrt_seq u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (eng_start),
    .radicand (sum_sq),
    .done     (eng_done),
    .root     (eng_root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= ID_W'(NREQ - 1);
      cur_id        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_mag   <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            x_q      <= bus.req_x[int'(grant_id) * W +: W];
            y_q      <= bus.req_y[int'(grant_id) * W +: W];
            cur_id   <= grant_id;
            last     <= grant_id;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: state <= ITER;
        ITER: begin
          if (eng_done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= cur_id;
            bus.rsp_mag   <= eng_root;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_req_scheduler.sv
// Directed and randomized checks of the shared magnitude scheduler.
module tb_mag_req_scheduler;
  import mag_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mag_req_scheduler_if bus ();

  mag_req_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int modelMag(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic setReq(input int id, input bit v, input int x, input int y);
    bus.req_valid[id]      = v;
    bus.req_x[id * W +: W] = W'(x);
    bus.req_y[id * W +: W] = W'(y);
  endtask

  // Waits at negedges for req_ready to become nonzero; returns 0 on timeout.
  task automatic waitGrant(output bit ok);
    int n;
    n = 0;
    while (bus.req_ready == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.req_ready != '0);
    if (!ok) checkOutput("grant_timeout", 0, 1);
  endtask

  // Counts posedges until rsp_valid, sampled #1 after each edge.
  task automatic waitRsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.rsp_valid) checkOutput("rsp_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input int id, input int x, input int y, input int expMag,
                               input bit checkLat, input int hold);
    bit ok;
    int lat;
    @(negedge clk);
    setReq(id, 1'b1, x, y);
    bus.rsp_ready = (hold == 0);
    #1;
    waitGrant(ok);
    if (!ok) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    checkOutput("req_ready", bus.req_ready, 32'd1 << id);
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
    waitRsp(lat);
    if (checkLat) checkOutput("latency", lat, W + 2);
    checkOutput("busy", bus.busy, 1);
    checkOutput("rsp_id", bus.rsp_id, id);
    checkOutput("rsp_mag", bus.rsp_mag, expMag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", bus.rsp_valid, 1);
      checkOutput("hold_mag", bus.rsp_mag, expMag);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rsp_retire", bus.rsp_valid, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_req_ready"}, bus.req_ready, 0);
    checkOutput({tag, "_rsp_id"}, bus.rsp_id, 0);
    checkOutput({tag, "_rsp_mag"}, bus.rsp_mag, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int lat;
    int prevCyc;
    int grantCyc;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single requests with hand-computed magnitudes.
    applyStimulus(0, 3, 4, 5, 1'b1, 0);
    applyStimulus(2, 255, 255, 360, 1'b1, 0);
    applyStimulus(1, 1, 1, 1, 1'b1, 0);
    applyStimulus(3, 0, 0, 0, 1'b1, 0);
    applyStimulus(1, 7, 24, 25, 1'b1, 0);
    applyStimulus(0, 100, 200, 223, 1'b1, 0);

    // All four requesters valid: grants rotate 0,1,2,3,0 every W+4 cycles.
    pulseReset();
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 3 * (i + 1), 4 * (i + 1));
    prevCyc = 0;
    for (int g = 0; g < 5; g++) begin
      #1;
      waitGrant(ok);
      if (!ok) break;
      checkOutput("rr_grant", bus.req_ready, 32'd1 << (g % NREQ));
      @(posedge clk);
      grantCyc = cyc;
      if (g > 0) checkOutput("rr_interval", grantCyc - prevCyc, W + 4);
      prevCyc = grantCyc;
      #1;
      if (g == 4) bus.req_valid = '0;
      waitRsp(lat);
      checkOutput("rr_rsp_id", bus.rsp_id, g % NREQ);
      checkOutput("rr_rsp_mag", bus.rsp_mag, 5 * ((g % NREQ) + 1));
      @(negedge clk);
    end
    bus.req_valid = '0;

    // Backpressure: result held in DONE while requester 1 waits.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    setReq(0, 1'b1, 6, 8);
    #1;
    waitGrant(ok);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    setReq(1, 1'b1, 5, 12);
    waitRsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", bus.rsp_valid, 1);
      checkOutput("bp_id", bus.rsp_id, 0);
      checkOutput("bp_mag", bus.rsp_mag, 10);
      checkOutput("bp_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    waitGrant(ok);
    checkOutput("bp_next_grant", bus.req_ready, 32'h2);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    waitRsp(lat);
    checkOutput("bp_next_id", bus.rsp_id, 1);
    checkOutput("bp_next_mag", bus.rsp_mag, 13);
    @(negedge clk);

    // Reset during ITER abandons the operation and restores the pointer.
    setReq(0, 1'b1, 3, 4);
    #1;
    waitGrant(ok);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("iter_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    checkOutput("no_stale_valid", bus.rsp_valid, 0);
    setReq(2, 1'b1, 255, 255);
    setReq(0, 1'b1, 3, 4);
    #1;
    checkOutput("post_reset_grant", bus.req_ready, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    waitRsp(lat);
    checkOutput("post_reset_id", bus.rsp_id, 0);
    checkOutput("post_reset_mag", bus.rsp_mag, 5);
    applyStimulus(2, 255, 255, 360, 1'b0, 0);

    // Randomized operands, requesters and response backpressure.
    for (int n = 0; n < 12; n++) begin
      int id;
      int x;
      int y;
      int hold;
      id   = $urandom_range(0, NREQ - 1);
      x    = $urandom_range(0, 255);
      y    = $urandom_range(0, 255);
      hold = $urandom_range(0, 3);
      applyStimulus(id, x, y, modelMag(x, y), 1'b1, hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
